// File: rtl/jtcps1_snd_pkg.sv
// Shared encodings for the CPS1 sound ROM arbiter: FSM states and grant ids.
// Latency: n/a (constants only).
// Backpressure: n/a.
package jtcps1_snd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;   // looking for a missing requester
    localparam state_t REQ  = 2'd1;   // mem_req raised, waiting for mem_ack
    localparam state_t WAIT = 2'd2;   // accepted, waiting for mem_rdy
    localparam state_t FILL = 2'd3;   // slot written, one settle cycle

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_PCM = 1'b1;

endpackage

// File: rtl/jtcps1_snd_romslot.sv
// One-word ROM cache slot: tag, 16-bit word, valid bit, hit compare and byte mux.
// Latency: hit and data are combinational from addr (0 cycles); fill lands on the next clk.
// Backpressure: none; the owner asserts fill for exactly one cycle per fetched word.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (clears valid, tag, word)
//   cs, addr             requester strobe and byte address
//   data, ok             byte selected by addr[0]; ok = cs & valid & tag match
//   miss                 cs with no hit
//   fill, fill_tag/word  write port used when a fetch returns
module jtcps1_snd_romslot
    import jtcps1_snd_pkg::*;
#(
    parameter int AW = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          ok,
    output logic          miss,
    input  logic          fill,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_word
);

    logic          valid;
    logic [AW-2:0] tag;
    logic [15:0]   word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            word  <= fill_word;
        end
    end

    // Hit tracks the live address, so ok drops the cycle addr leaves the word.
    assign ok   = cs & valid & (addr[AW-1:1] == tag);
    assign miss = cs & ~ok;
    // Low byte of the SDRAM word holds the even address.
    assign data = addr[0] ? word[15:8] : word[7:0];

endmodule

// File: rtl/jtcps1_snd_romarb.sv
// Shares one 16-bit SDRAM read port between the Z80 program ROM and the OKI ADPCM ROM.
// Latency: cache hit 0 cycles; miss-to-ok = ack delay + rdy delay + 2 cycles minimum.
// Backpressure: mem_req held until mem_ack; requesters wait (x_ok low) while the port is busy.
//
// Optional feature: define JTCPS1_SNDARB_RR_EN for round-robin on simultaneous misses;
// otherwise the Z80 always wins a tie.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_cs/addr/data/ok        Z80 ROM byte read port
//   pcm_cs/addr/data/ok        ADPCM ROM byte read port
//   mem_addr, mem_req, mem_ack SDRAM word request handshake
//   mem_rdy, mem_dout          SDRAM read data strobe and word
module jtcps1_snd_romarb
    import jtcps1_snd_pkg::*;
#(
    parameter int                CPU_AW     = 16,
    parameter int                PCM_AW     = 18,
    parameter int                MEM_AW     = 22,
    parameter logic [MEM_AW-1:0] CPU_OFFSET = '0,
    parameter logic [MEM_AW-1:0] PCM_OFFSET = MEM_AW'(32'h10000)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cs,
    input  logic [CPU_AW-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ok,
    input  logic              pcm_cs,
    input  logic [PCM_AW-1:0] pcm_addr,
    output logic [7:0]        pcm_data,
    output logic              pcm_ok,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic              mem_rdy,
    input  logic [15:0]       mem_dout
);

    state_t            state, next_state;
    logic              grant, next_grant;
    logic              cpu_miss, pcm_miss, cpu_pend, pcm_pend, start;
    logic              cpu_fill, pcm_fill;
    logic [CPU_AW-2:0] cpu_ftag;
    logic [PCM_AW-2:0] pcm_ftag;
    logic [MEM_AW-1:0] next_addr;

    jtcps1_snd_romslot #(.AW(CPU_AW)) u_cpu (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cpu_cs),
        .addr      (cpu_addr),
        .data      (cpu_data),
        .ok        (cpu_ok),
        .miss      (cpu_miss),
        .fill      (cpu_fill),
        .fill_tag  (cpu_ftag),
        .fill_word (mem_dout)
    );

    jtcps1_snd_romslot #(.AW(PCM_AW)) u_pcm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (pcm_cs),
        .addr      (pcm_addr),
        .data      (pcm_data),
        .ok        (pcm_ok),
        .miss      (pcm_miss),
        .fill      (pcm_fill),
        .fill_tag  (pcm_ftag),
        .fill_word (mem_dout)
    );

    // Arbiter: the requester currently owning the port is never re-pended.
    always_comb begin
        cpu_pend   = cpu_miss & ~((state != IDLE) & (grant == GNT_CPU));
        pcm_pend   = pcm_miss & ~((state != IDLE) & (grant == GNT_PCM));
        start      = (state == IDLE) & (cpu_pend | pcm_pend);
        next_grant = grant;
        if (cpu_pend && pcm_pend) begin
`ifdef JTCPS1_SNDARB_RR_EN
            next_grant = ~grant;
`else
            next_grant = GNT_CPU;
`endif
        end else if (cpu_pend) begin
            next_grant = GNT_CPU;
        end else if (pcm_pend) begin
            next_grant = GNT_PCM;
        end
        // Word address wraps modulo the SDRAM address space.
        if (next_grant == GNT_CPU)
            next_addr = CPU_OFFSET + MEM_AW'(cpu_addr[CPU_AW-1:1]);
        else
            next_addr = PCM_OFFSET + MEM_AW'(pcm_addr[PCM_AW-1:1]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Fetch context: the tag is frozen at grant so a moving address cannot
    // corrupt the fill. grant doubles as the last-grant memory for round-robin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant    <= GNT_PCM;
            cpu_ftag <= '0;
            pcm_ftag <= '0;
            mem_addr <= '0;
        end else if (start) begin
            grant    <= next_grant;
            mem_addr <= next_addr;
            if (next_grant == GNT_CPU) cpu_ftag <= cpu_addr[CPU_AW-1:1];
            else                       pcm_ftag <= pcm_addr[PCM_AW-1:1];
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)   next_state = REQ;
            REQ:     if (mem_ack) next_state = WAIT;   // a same-cycle mem_rdy is dropped
            WAIT:    if (mem_rdy) next_state = FILL;
            FILL:                 next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Outputs: mem_rdy only matters while waiting for data.
    always_comb begin
        mem_req  = (state == REQ);
        cpu_fill = (state == WAIT) & mem_rdy & (grant == GNT_CPU);
        pcm_fill = (state == WAIT) & mem_rdy & (grant == GNT_PCM);
    end

endmodule

// File: tb/tb_jtcps1_snd_romarb.sv
// Directed bench for the CPS1 sound ROM arbiter with a hand-driven SDRAM controller.
// Latency: n/a.
// Backpressure: controller ack/rdy delays chosen per step.
module tb_jtcps1_snd_romarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        pcm_cs;
    logic [17:0] pcm_addr;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic [21:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_rdy;
    logic [15:0] mem_dout;

    int total = 0;
    int bad   = 0;

    jtcps1_snd_romarb #(
        .CPU_AW     (16),
        .PCM_AW     (18),
        .MEM_AW     (22),
        .CPU_OFFSET (22'h0),
        .PCM_OFFSET (22'h3FFFFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_cs   (cpu_cs),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_ok   (cpu_ok),
        .pcm_cs   (pcm_cs),
        .pcm_addr (pcm_addr),
        .pcm_data (pcm_data),
        .pcm_ok   (pcm_ok),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_rdy  (mem_rdy),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for mem_req and returns the requested word address.
    task automatic wait_req(input string tag, output logic [21:0] a);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, {31'd0, mem_req}, 32'd1);
        a = mem_addr;
    endtask

    task automatic ack_after(input int d);
        repeat (d) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic rdy_after(input int d, input logic [15:0] w);
        repeat (d - 1) @(negedge clk);
        mem_dout = w;
        mem_rdy  = 1'b1;
        @(negedge clk);
        mem_rdy  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [21:0] a;
        logic [21:0] exp6 [3];
        logic        req_seen;

        rst_n = 1'b0; cpu_cs = 1'b0; cpu_addr = '0; pcm_cs = 1'b0; pcm_addr = '0;
        mem_ack = 1'b0; mem_rdy = 1'b0; mem_dout = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
        chk("rst_cpu_ok",   {31'd0, cpu_ok}, 32'd0);
        chk("rst_pcm_ok",   {31'd0, pcm_ok}, 32'd0);
        chk("rst_cpu_data", {24'd0, cpu_data}, 32'd0);
        chk("rst_pcm_data", {24'd0, pcm_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic CPU miss, then odd byte served from cache
        cpu_addr = 16'h0100; cpu_cs = 1'b1;
        #1 chk("t1_miss_ok", {31'd0, cpu_ok}, 32'd0);
        wait_req("t1", a);
        chk("t1_mem_addr", {10'd0, a}, 32'h80);
        ack_after(2);
        chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t1_wait_ok", {31'd0, cpu_ok}, 32'd0);
        rdy_after(5, 16'hBEEF);
        chk("t1_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t1_data_lo", {24'd0, cpu_data}, 32'hEF);
        cpu_addr = 16'h0101;
        #1;
        chk("t1_odd_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t1_data_hi", {24'd0, cpu_data}, 32'hBE);
        req_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            req_seen = req_seen | mem_req;
        end
        chk("t1_no_refetch", {31'd0, req_seen}, 32'd0);
        cpu_cs = 1'b0;
        @(negedge clk);

        // 2: PCM top address, offset sum wraps
        pcm_addr = 18'h3FFFF; pcm_cs = 1'b1;
        wait_req("t2", a);
        chk("t2_mem_addr_wrap", {10'd0, a}, 32'h01FFFE);
        ack_after(1);
        rdy_after(2, 16'hA55A);
        chk("t2_ok", {31'd0, pcm_ok}, 32'd1);
        chk("t2_data_hi", {24'd0, pcm_data}, 32'hA5);
        pcm_addr = 18'h3FFFE;
        #1 chk("t2_data_lo", {24'd0, pcm_data}, 32'h5A);
        pcm_cs = 1'b0;
        @(negedge clk);

        // 3: simultaneous misses; last grant was PCM so CPU goes first in either build
        cpu_addr = 16'h0400; pcm_addr = 18'h00100; cpu_cs = 1'b1; pcm_cs = 1'b1;
        wait_req("t3a", a);
        chk("t3_first_cpu", {10'd0, a}, 32'h200);
        ack_after(1);
        rdy_after(1, 16'h1122);
        chk("t3_cpu_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t3_pcm_wait", {31'd0, pcm_ok}, 32'd0);
        chk("t3_cpu_data", {24'd0, cpu_data}, 32'h22);
        wait_req("t3b", a);
        chk("t3_second_pcm", {10'd0, a}, 32'h00007F);
        ack_after(1);
        rdy_after(1, 16'h3344);
        chk("t3_pcm_ok", {31'd0, pcm_ok}, 32'd1);
        chk("t3_pcm_data", {24'd0, pcm_data}, 32'h44);
        cpu_cs = 1'b0; pcm_cs = 1'b0;
        @(negedge clk);

        // 4: address moves during WAIT; fill uses the frozen tag
        cpu_addr = 16'h0100; cpu_cs = 1'b1;
        wait_req("t4a", a);
        chk("t4_first_addr", {10'd0, a}, 32'h80);
        ack_after(1);
        cpu_addr = 16'h0200;
        rdy_after(2, 16'hCAFE);
        chk("t4_ok_live_addr", {31'd0, cpu_ok}, 32'd0);
        cpu_addr = 16'h0101;
        #1;
        chk("t4_filltag_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t4_filltag_data", {24'd0, cpu_data}, 32'hCA);
        cpu_addr = 16'h0200;
        wait_req("t4b", a);
        chk("t4_second_addr", {10'd0, a}, 32'h100);
        ack_after(1);
        chk("t4_wait_ok", {31'd0, cpu_ok}, 32'd0);
        rdy_after(1, 16'hD00D);
        chk("t4_final_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t4_final_data", {24'd0, cpu_data}, 32'h0D);
        cpu_cs = 1'b0;
        @(negedge clk);

        // 5: reset during WAIT, then a stray rdy
        cpu_addr = 16'h0600; cpu_cs = 1'b1;
        wait_req("t5", a);
        ack_after(1);
        rst_n = 1'b0; cpu_cs = 1'b0;
        @(negedge clk);
        chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t5_rst_addr", {10'd0, mem_addr}, 32'd0);
        rst_n = 1'b1; mem_dout = 16'hFFFF; mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("t5_stray_req", {31'd0, mem_req}, 32'd0);
        cpu_cs = 1'b1; pcm_cs = 1'b1; cpu_addr = 16'h0600; pcm_addr = 18'h0;
        #1;
        chk("t5_cpu_inval_a", {31'd0, cpu_ok}, 32'd0);
        chk("t5_pcm_inval_a", {31'd0, pcm_ok}, 32'd0);
        cpu_addr = 16'h0400; pcm_addr = 18'h00100;
        #1;
        chk("t5_cpu_inval_b", {31'd0, cpu_ok}, 32'd0);
        chk("t5_pcm_inval_b", {31'd0, pcm_ok}, 32'd0);
        wait_req("t5b", a);
        chk("t5_idle_cpu", {10'd0, a}, 32'h200);
        ack_after(1);
        rdy_after(1, 16'h5566);
        wait_req("t5c", a);
        chk("t5_idle_pcm", {10'd0, a}, 32'h00007F);
        ack_after(1);
        rdy_after(1, 16'h7788);
        chk("t5_cpu_ok", {31'd0, cpu_ok}, 32'd1);
        chk("t5_pcm_data", {24'd0, pcm_data}, 32'h88);
        cpu_cs = 1'b0; pcm_cs = 1'b0;
        @(negedge clk);

        // 6: CPU keeps missing while PCM is pending
`ifdef JTCPS1_SNDARB_RR_EN
        exp6[0] = 22'h800; exp6[1] = 22'h0000FF; exp6[2] = 22'h801;
`else
        exp6[0] = 22'h800; exp6[1] = 22'h801;    exp6[2] = 22'h802;
`endif
        cpu_addr = 16'h1000; pcm_addr = 18'h00200; cpu_cs = 1'b1; pcm_cs = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req("t6", a);
            chk($sformatf("t6_grant%0d", k), {10'd0, a}, {10'd0, exp6[k]});
            ack_after(1);
            rdy_after(1, 16'h6000 + 16'(k));
            if (exp6[k] != 22'h0000FF) cpu_addr = cpu_addr + 16'd2;
        end
        cpu_cs = 1'b0;
`ifdef JTCPS1_SNDARB_RR_EN
        chk("t6_pcm_ok", {31'd0, pcm_ok}, 32'd1);
        chk("t6_pcm_data", {24'd0, pcm_data}, 32'h01);
`else
        chk("t6_pcm_starved", {31'd0, pcm_ok}, 32'd0);
        wait_req("t6p", a);
        chk("t6_pcm_last", {10'd0, a}, 32'h0000FF);
        ack_after(1);
        rdy_after(1, 16'h6003);
        chk("t6_pcm_ok", {31'd0, pcm_ok}, 32'd1);
        chk("t6_pcm_data", {24'd0, pcm_data}, 32'h03);
`endif
        pcm_cs = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
